// File: rtl/lru_way_tracker_pkg.sv
// Shared types and sizing helpers for the LRU way tracker (package lru_pkg).
package lru_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;

  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int set_width(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  // Age value carried by the least recently used way of a set.
  function automatic int age_oldest(input int ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/lru_way_select.sv
// Combinational per-set resolver: hit detection and victim choice
// (lowest invalid way, else the way holding the oldest age).
module lru_way_select
  import lru_pkg::*;
#(
  parameter int WAYS      = 8,
  parameter int TAG_WIDTH = 8,
  parameter int WAY_WIDTH = way_width(WAYS)
) (
  input  logic [WAYS-1:0][TAG_WIDTH-1:0] tags,
  input  logic [WAYS-1:0]                valids,
  input  logic [WAYS-1:0][WAY_WIDTH-1:0] ages,
  input  logic [TAG_WIDTH-1:0]           req_tag,
  output logic                           hit,
  output logic [WAY_WIDTH-1:0]           hit_way,
  output logic [WAY_WIDTH-1:0]           victim_way,
  output logic [WAY_WIDTH-1:0]           victim_age
);

  localparam logic [WAY_WIDTH-1:0] AGE_OLDEST = WAY_WIDTH'(age_oldest(WAYS));

  logic [WAYS-1:0]      match;
  logic                 found_inv;
  logic [WAY_WIDTH-1:0] inv_way;
  logic [WAY_WIDTH-1:0] old_way;

  for (genvar w = 0; w < WAYS; w++) begin : g_match
    assign match[w] = valids[w] && (tags[w] == req_tag);
  end

  // Scan high to low so the lowest index wins every priority.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit     = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!valids[w]) begin
        found_inv = 1'b1;
        inv_way   = WAY_WIDTH'(w);
      end
      if (ages[w] == AGE_OLDEST) old_way = WAY_WIDTH'(w);
    end
    victim_way = found_inv ? inv_way : old_way;
    victim_age = ages[victim_way];
  end

endmodule

// File: rtl/lru_way_tracker.sv
// True-LRU replacement engine for a WAYS x SETS cache: IDLE -> LOOKUP -> UPDATE.
// Optional hit/miss/evict counters under `LRU_WAY_TRACKER_STATS_EN.
module lru_way_tracker
  import lru_pkg::*;
#(
  parameter  int WAYS      = 8,
  parameter  int SETS      = 16,
  parameter  int TAG_WIDTH = 8,
  localparam int WAY_WIDTH = way_width(WAYS),
  localparam int SET_WIDTH = set_width(SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SET_WIDTH-1:0] req_set,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 req_write,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_WIDTH-1:0] resp_way,
  output logic                 resp_evict,
  output logic [TAG_WIDTH-1:0] resp_evict_tag
`ifdef LRU_WAY_TRACKER_STATS_EN
  ,
  output logic [15:0]          stat_hits,
  output logic [15:0]          stat_misses,
  output logic [15:0]          stat_evicts
`endif
);

  state_t state, next_state;

  logic [SETS-1:0][WAYS-1:0][TAG_WIDTH-1:0] tag_arr;
  logic [SETS-1:0][WAYS-1:0]                valid_arr;
  logic [SETS-1:0][WAYS-1:0]                dirty_arr;
  logic [SETS-1:0][WAYS-1:0][WAY_WIDTH-1:0] age_arr;

  logic [SET_WIDTH-1:0] set_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 write_q;

  logic                 hit_q, vvalid_q, vdirty_q;
  logic [WAY_WIDTH-1:0] way_q, old_age_q;
  logic [TAG_WIDTH-1:0] vtag_q;

  logic                 sel_hit;
  logic [WAY_WIDTH-1:0] sel_hit_way, sel_victim_way, sel_victim_age;
  logic [WAY_WIDTH-1:0] target_way, target_age;
  logic                 evict;

  lru_way_select #(
    .WAYS(WAYS), .TAG_WIDTH(TAG_WIDTH), .WAY_WIDTH(WAY_WIDTH)
  ) u_sel (
    .tags      (tag_arr[set_q]),
    .valids    (valid_arr[set_q]),
    .ages      (age_arr[set_q]),
    .req_tag   (tag_q),
    .hit       (sel_hit),
    .hit_way   (sel_hit_way),
    .victim_way(sel_victim_way),
    .victim_age(sel_victim_age)
  );

  assign target_way = sel_hit ? sel_hit_way : sel_victim_way;
  assign target_age = sel_hit ? age_arr[set_q][sel_hit_way] : sel_victim_age;
  assign evict      = !hit_q && vvalid_q && vdirty_q;
  assign req_ready  = (state == IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = LOOKUP;
      LOOKUP:  next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      set_q          <= '0;
      tag_q          <= '0;
      write_q        <= 1'b0;
      hit_q          <= 1'b0;
      way_q          <= '0;
      old_age_q      <= '0;
      vtag_q         <= '0;
      vvalid_q       <= 1'b0;
      vdirty_q       <= 1'b0;
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_way       <= '0;
      resp_evict     <= 1'b0;
      resp_evict_tag <= '0;
      tag_arr        <= '0;
      valid_arr      <= '0;
      dirty_arr      <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_arr[s][w] <= WAY_WIDTH'(w);
    end else begin
      state      <= next_state;
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        set_q   <= req_set;
        tag_q   <= req_tag;
        write_q <= req_write;
      end
      if (state == LOOKUP) begin
        hit_q     <= sel_hit;
        way_q     <= target_way;
        old_age_q <= target_age;
        vtag_q    <= tag_arr[set_q][sel_victim_way];
        vvalid_q  <= valid_arr[set_q][sel_victim_way];
        vdirty_q  <= dirty_arr[set_q][sel_victim_way];
      end
      if (state == UPDATE) begin
        resp_valid     <= 1'b1;
        resp_hit       <= hit_q;
        resp_way       <= way_q;
        resp_evict     <= evict;
        resp_evict_tag <= (!hit_q && vvalid_q) ? vtag_q : '0;
        // Only ways younger than the target age; ages stay a permutation.
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_WIDTH'(w) == way_q)
            age_arr[set_q][w] <= '0;
          else if (age_arr[set_q][w] < old_age_q)
            age_arr[set_q][w] <= age_arr[set_q][w] + 1'b1;
        end
        if (hit_q) begin
          dirty_arr[set_q][way_q] <= dirty_arr[set_q][way_q] | write_q;
        end else begin
          tag_arr[set_q][way_q]   <= tag_q;
          valid_arr[set_q][way_q] <= 1'b1;
          dirty_arr[set_q][way_q] <= write_q;
        end
      end
    end
  end

`ifdef LRU_WAY_TRACKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else if (state == UPDATE) begin
      if (hit_q && stat_hits != '1)    stat_hits   <= stat_hits + 16'd1;
      if (!hit_q && stat_misses != '1) stat_misses <= stat_misses + 16'd1;
      if (evict && stat_evicts != '1)  stat_evicts <= stat_evicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lru_way_tracker.sv
// Scoreboard bench for lru_way_tracker: stimulus pushes expected responses,
// a negedge monitor pops and compares on every resp_valid pulse.
module tb_lru_way_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_set;
  logic [7:0] req_tag;
  logic       req_write;
  logic       resp_valid;
  logic       resp_hit;
  logic [2:0] resp_way;
  logic       resp_evict;
  logic [7:0] resp_evict_tag;
`ifdef LRU_WAY_TRACKER_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_evicts;
`endif

  always #5 clk = ~clk;

  lru_way_tracker #(.WAYS(8), .SETS(16), .TAG_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_set       (req_set),
    .req_tag       (req_tag),
    .req_write     (req_write),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_way      (resp_way),
    .resp_evict    (resp_evict),
    .resp_evict_tag(resp_evict_tag)
`ifdef LRU_WAY_TRACKER_STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses),
    .stat_evicts   (stat_evicts)
`endif
  );

  typedef struct {
    int       set;
    bit       hit;
    int       way;
    bit       evict;
    int       etag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: timestamp LRU, independent of the age encoding.
  logic [7:0] m_tag  [16][8];
  bit         m_valid[16][8];
  bit         m_dirty[16][8];
  int         m_ts   [16][8];
  int         m_time;
  int         m_hits, m_misses, m_evicts;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 8; w++) begin
        m_tag[s][w] = 8'h00; m_valid[s][w] = 0; m_dirty[s][w] = 0; m_ts[s][w] = -w;
      end
    m_time = 0; m_hits = 0; m_misses = 0; m_evicts = 0;
  endtask

  task automatic model_access(input int s, input logic [7:0] t, input bit wr, output exp_t e);
    int way, inv;
    bit hit;
    hit = 0; way = 0; inv = -1;
    for (int w = 7; w >= 0; w--) begin
      if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; way = w; end
      if (!m_valid[s][w]) inv = w;
    end
    e.set = s; e.hit = hit; e.evict = 0; e.etag = 0;
    if (hit) begin
      m_dirty[s][way] |= wr;
      m_hits++;
    end else begin
      if (inv >= 0) way = inv;
      else begin
        way = 0;
        for (int w = 1; w < 8; w++) if (m_ts[s][w] < m_ts[s][way]) way = w;
      end
      e.etag  = m_valid[s][way] ? int'(m_tag[s][way]) : 0;
      e.evict = m_valid[s][way] && m_dirty[s][way];
      if (e.evict) m_evicts++;
      m_misses++;
      m_tag[s][way] = t; m_valid[s][way] = 1; m_dirty[s][way] = wr;
    end
    e.way = way;
    m_time++;
    m_ts[s][way] = m_time;
  endtask

  function automatic exp_t mk(input int s, input bit h, input int w, input bit ev, input int et);
    exp_t e;
    e.set = s; e.hit = h; e.way = w; e.evict = ev; e.etag = et;
    return e;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", req_ready, 1);
  endtask

  // Issue one request; hand=1 pushes the given hand-computed expectation.
  task automatic access(input int s, input logic [7:0] t, input bit wr,
                        input bit hand, input exp_t he);
    exp_t me;
    @(negedge clk);
    wait_ready();
    model_access(s, t, wr, me);
    exp_q.push_back(hand ? he : me);
    req_valid = 1'b1; req_set = 4'(s); req_tag = t; req_write = wr;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", resp_valid, 0);
      end else begin
        exp_t e;
        bit [7:0] seen;
        e = exp_q.pop_front();
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_way", resp_way, e.way);
        chk("resp_evict", resp_evict, e.evict);
        chk("resp_evict_tag", resp_evict_tag, e.etag);
        seen = '0;
        for (int w = 0; w < 8; w++) seen[dut.age_arr[e.set][w]] = 1'b1;
        chk("age_perm", seen, 8'hFF);
      end
    end
  end

  initial begin
    exp_t dummy;
    dummy = mk(0, 0, 0, 0, 0);
    rst = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0; req_write = 1'b0;
    model_reset();
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_hit", resp_hit, 0);
    chk("reset_resp_way", resp_way, 0);
    chk("reset_resp_evict", resp_evict, 0);
    chk("reset_resp_evict_tag", resp_evict_tag, 0);
    do_reset();

    // First access: cold miss into way 0; ready low for exactly two cycles.
    access(3, 8'h11, 0, 1, mk(3, 0, 0, 0, 0));
    chk("ready_lookup", req_ready, 0);
    @(posedge clk); #1;
    chk("ready_update", req_ready, 0);
    @(posedge clk); #1;
    chk("ready_back", req_ready, 1);
    chk("resp_valid_latency", resp_valid, 1);
    for (int w = 0; w < 8; w++) chk("age_set3", dut.age_arr[3][w], w);

    // Fill set 5, hit on way 0, then a clean store miss evicts way 1.
    for (int i = 0; i < 8; i++) access(5, 8'(8'h20 + i), 0, 1, mk(5, 0, i, 0, 0));
    access(5, 8'h20, 0, 1, mk(5, 1, 0, 0, 0));
    access(5, 8'h30, 1, 1, mk(5, 0, 1, 0, 8'h21));
    drain();
    chk("age_set5_way1", dut.age_arr[5][1], 0);
    chk("age_set5_way0", dut.age_arr[5][0], 1);

    // Dirty line in way 0 of set 2 becomes LRU and is written back.
    access(2, 8'h40, 1, 1, mk(2, 0, 0, 0, 0));
    for (int i = 1; i < 8; i++) access(2, 8'(8'h40 + i), 0, 1, mk(2, 0, i, 0, 0));
    for (int i = 1; i < 8; i++) access(2, 8'(8'h40 + i), 0, 1, mk(2, 1, i, 0, 0));
    access(2, 8'h50, 0, 1, mk(2, 0, 0, 1, 8'h40));
    drain();
    repeat (2) @(negedge clk);
    chk("hold_resp_valid", resp_valid, 0);
    chk("hold_evict", resp_evict, 1);
    chk("hold_evict_tag", resp_evict_tag, 8'h40);

`ifdef LRU_WAY_TRACKER_STATS_EN
    chk("stat_hits", stat_hits, m_hits);
    chk("stat_misses", stat_misses, m_misses);
    chk("stat_evicts", stat_evicts, m_evicts);
`endif

    // Reset during LOOKUP aborts the access without a response.
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_set = 4'd9; req_tag = 8'h33; req_write = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    access(9, 8'h33, 0, 1, mk(9, 0, 0, 0, 0));
    drain();

    // Random traffic against the model; small tag pool gives hits and evicts.
    for (int i = 0; i < 1000; i++)
      access($urandom_range(0, 15), 8'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 0, dummy);
    drain();

`ifdef LRU_WAY_TRACKER_STATS_EN
    chk("stat_hits_rand", stat_hits, m_hits);
    chk("stat_misses_rand", stat_misses, m_misses);
    chk("stat_evicts_rand", stat_evicts, m_evicts);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
